// File: rtl/gpio_pkg.sv
// Shared register map for the GPIO block with edge-triggered interrupts.
// Only address bits [4:0] are decoded; the rest alias.
package gpio_pkg;

  localparam int unsigned GPIO_ADDR_W = 5;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR      = 5'h00;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT      = 5'h04;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IN       = 5'h08;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_EN   = 5'h0C;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_MODE = 5'h10;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_STAT = 5'h14;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT_SET  = 5'h18;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT_CLR  = 5'h1C;

endpackage

// File: rtl/gpio_sync.sv
// Per-bit flop-chain synchroniser for asynchronous pad inputs.
// Output is the last stage; synchronous active-high reset clears every stage.
module gpio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  // Stage 0 samples the pad; each later stage copies its predecessor.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO register block with synchronised inputs and optional per-pin edge interrupts.
// Interrupt logic is present only when macro GPIO_IRQ_EN is defined.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_IO      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              irq_o
);

  logic [GPIO_ADDR_W-1:0] reg_addr;
  logic [NUM_IO-1:0]      wdata;
  logic [NUM_IO-1:0]      in_sync;
  logic [NUM_IO-1:0]      dir_q, dir_d;
  logic [NUM_IO-1:0]      out_q, out_d;
  logic [NUM_IO-1:0]      rdata;
  logic                   unused_bits;

  assign reg_addr    = addr_i[GPIO_ADDR_W-1:0];
  assign wdata       = data_i[NUM_IO-1:0];
  assign unused_bits = ^{addr_i[31:GPIO_ADDR_W], data_i};

  gpio_sync #(
    .WIDTH  (NUM_IO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (io_pin_i),
    .q_o (in_sync)
  );

  // Direction and output registers, including atomic set/clear aliases.
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (we_i) begin
      case (reg_addr)
        GPIO_DIR:     dir_d = wdata;
        GPIO_OUT:     out_d = wdata;
        GPIO_OUT_SET: out_d = out_q | wdata;
        GPIO_OUT_CLR: out_d = out_q & ~wdata;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= '0;
      out_q <= '0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  assign io_out_o = out_q;
  assign io_oe_o  = dir_q;

`ifdef GPIO_IRQ_EN
  logic [NUM_IO-1:0] en_q,   en_d;
  logic [NUM_IO-1:0] mode_q, mode_d;
  logic [NUM_IO-1:0] stat_q, stat_d;
  logic [NUM_IO-1:0] prev_q, prev_d;
  logic [NUM_IO-1:0] edge_c;
  logic [NUM_IO-1:0] w1c;

  // Edge detect against the delayed IN copy; output pins never raise status.
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    prev_d = in_sync;
    if (we_i) begin
      case (reg_addr)
        GPIO_IRQ_EN:   en_d   = wdata;
        GPIO_IRQ_MODE: mode_d = wdata;
        GPIO_IRQ_STAT: w1c    = wdata;
        default:       ;
      endcase
    end
    edge_c = (mode_q & ~in_sync & prev_q) | (~mode_q & in_sync & ~prev_q);
    stat_d = (stat_q & ~w1c) | (edge_c & ~dir_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= '0;
      mode_q <= '0;
      stat_q <= '0;
      prev_q <= '0;
    end else begin
      en_q   <= en_d;
      mode_q <= mode_d;
      stat_q <= stat_d;
      prev_q <= prev_d;
    end
  end

  assign irq_o = |(stat_q & en_q);
`else
  assign irq_o = 1'b0;
`endif

  // Combinational read mux; undecoded and write-only offsets read zero.
  always_comb begin
    rdata = '0;
    case (reg_addr)
      GPIO_DIR:      rdata = dir_q;
      GPIO_OUT:      rdata = out_q;
      GPIO_IN:       rdata = in_sync;
`ifdef GPIO_IRQ_EN
      GPIO_IRQ_EN:   rdata = en_q;
      GPIO_IRQ_MODE: rdata = mode_q;
      GPIO_IRQ_STAT: rdata = stat_q;
`endif
      default:       rdata = '0;
    endcase
  end

  assign data_o = 32'(rdata);

endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 SHALL have parameter NUM_IO, default 8, number of IO pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-003 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port we_i, input, 1, bus write enable.
REQ-006 SHALL have port addr_i, input, 32, register address; only addr_i[4:0] decoded.
REQ-007 SHALL have port data_i, input, 32, bus write data.
REQ-008 SHALL have port data_o, output, 32, bus read data.
REQ-009 SHALL have port io_pin_i, input, NUM_IO, asynchronous pad input levels.
REQ-010 SHALL have port io_out_o, output, NUM_IO, pad output values (equal to OUT register).
REQ-011 SHALL have port io_oe_o, output, NUM_IO, pad output enables (equal to DIR register).
REQ-012 SHALL have port irq_o, output, 1, level interrupt request.

Function
REQ-013 SHALL decode registers: 0x00 DIR (RW, 1=output), 0x04 OUT (RW), 0x08 IN (RO), 0x0C IRQ_EN (RW), 0x10 IRQ_MODE (RW, 0=rising, 1=falling), 0x14 IRQ_STAT (RW1C), 0x18 OUT_SET (WO), 0x1C OUT_CLR (WO).
REQ-014 SHALL update writable registers on the clk edge where we_i=1, using data_i[NUM_IO-1:0]; bits at or above NUM_IO ignored.
REQ-015 SHALL, on a write to OUT_SET, set OUT bits where data_i=1; on OUT_CLR, clear OUT bits where data_i=1; other bits unchanged.
REQ-016 SHALL drive data_o combinationally from addr_i; bits at or above NUM_IO read 0; OUT_SET, OUT_CLR and undecoded addresses read 0.
REQ-017 SHALL pass io_pin_i through a SYNC_STAGES-deep flop chain per pin; IN reflects the last stage, so a pin change is visible in IN SYNC_STAGES edges later.
REQ-018 SHALL keep one delayed copy of synchronised IN; a rising edge is IN=1 and prev=0, a falling edge is IN=0 and prev=1.
REQ-019 SHALL set IRQ_STAT[i] on the edge after a qualifying edge (per IRQ_MODE[i]) only when DIR[i]=0 and IRQ_EN[i]=1; pin change to status set takes SYNC_STAGES+1 edges.
REQ-020 SHALL clear IRQ_STAT bits written with 1 at 0x14; on the same cycle as a new event on the same bit, set wins.
REQ-021 SHALL leave IRQ_STAT bits unchanged when IRQ_EN or DIR changes; pending bits clear only by W1C or reset.
REQ-022 SHALL drive irq_o = OR of (IRQ_STAT & IRQ_EN) combinationally from registers.
REQ-023 SHALL sample IN for input and output pins alike; edge detection is suppressed for output pins only.

Reset
REQ-024 SHALL on rst=1 at a clk edge clear DIR, OUT, IRQ_EN, IRQ_MODE, IRQ_STAT, all synchroniser flops and the prev copy to 0.
REQ-025 SHALL give io_out_o=0, io_oe_o=0 and irq_o=0 from the first edge with rst=1, with data_o reading 0 for every address.
REQ-026 SHALL discard an edge in flight when reset is asserted mid-synchronisation; no status bit sets after reset until IRQ_EN is written.

Configuration
REQ-027 SHALL, with macro GPIO_IRQ_EN defined, implement REQ-018 to REQ-022 as specified.
REQ-028 SHALL, without GPIO_IRQ_EN, omit the IRQ_EN, IRQ_MODE, IRQ_STAT and prev flops, tie irq_o to 0, read those addresses as 0 and ignore writes to them.

Structure
REQ-029 SHALL place register offset constants (GPIO_DIR ... GPIO_OUT_CLR) in shared package gpio_pkg.
REQ-030 SHALL implement the synchroniser as sub-module gpio_sync, parameterised by width and SYNC_STAGES.

Verification
REQ-031 SHALL cover: write DIR=0xFF, then OUT=0xA5 -> io_oe_o=0xFF, io_out_o=0xA5; read 0x04 returns 0x000000A5.
REQ-032 SHALL cover: OUT=0x0F, then OUT_SET=0x30, then OUT_CLR=0x01 -> OUT=0x3E; read 0x18 returns 0.
REQ-033 SHALL cover: DIR=0, IRQ_EN=0x01, MODE=0, pin0 rises at edge N -> IN[0]=1 at N+2, IRQ_STAT=0x01 and irq_o=1 at N+3.
REQ-034 SHALL cover: pending STAT[0], W1C 0x01 in the same cycle as a new rising edge on pin0 -> STAT[0] stays 1; a later W1C clears it and irq_o=0.
REQ-035 SHALL cover: MODE[3]=1, IRQ_EN[3]=1, pin3 falls -> STAT[3]=1; pin3 rises -> no change; DIR[3]=1 then pin3 toggles -> no status set.
REQ-036 SHALL cover: rst pulsed mid-synchronisation -> all outputs 0, STAT=0; build without GPIO_IRQ_EN -> irq_o=0 and 0x0C to 0x14 read 0.
